mem_wb_stage: RTL and testbench

MEM-to-WB boundary block of the RV32I 5-stage pipeline. It drives the data-memory port for loads and stores, waiting on the memory's req/ack handshake, and raises a stall request while an access is outstanding. It sign- or zero-extends load data and registers the write-back bundle (destination, data, write enable) into WB. It consumes reg_dest_MEM and the other MEM-stage signals, and follows the same bubble/flush register discipline as the EX/MEM registers.

---
 rtl/mem_wb_stage.sv | 270 +++++++++++++++++++++++++++
 tb/tb_mem_wb_stage.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM-to-WB boundary of the RV32I 5-stage pipeline.
// Drives the data-memory req/ack port for loads and stores. Holds stall_req
// while an access is outstanding. Extends load data and registers the
// write-back bundle into WB, with the same bubble/flush discipline as EX/MEM.
// Optional feature: define DMEM_TIMEOUT_EN to bound the ack wait to
// TIMEOUT_CYCLES cycles and report abandoned accesses on bus_err_WB.
module mem_wb_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  reg_dest_MEM,
  input  logic [31:0] alu_result_MEM,
  input  logic [31:0] store_data_MEM,
  input  logic [2:0]  funct3_MEM,
  input  logic        mem_read_MEM,
  input  logic        mem_write_MEM,
  input  logic        reg_write_MEM,
  input  logic        bubbleW,
  input  logic        flushW,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall_req,
  output logic [4:0]  reg_dest_WB,
  output logic [31:0] wb_data_WB,
  output logic        reg_write_WB,
  output logic        misalign_WB,
  output logic        bus_err_WB
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state;
  logic        is_mem;
  logic        width_bad;
  logic        align_bad;
  logic        bad;
  logic        access;
  logic        timeout;
  logic        completes;
  logic [1:0]  lane;
  logic [3:0]  strb;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] load_data;
  logic [31:0] cap_data;
  logic [31:0] buf_data;

  assign is_mem = mem_read_MEM | mem_write_MEM;
  assign lane   = alu_result_MEM[1:0];

  // Classify the access: illegal width code or misaligned address.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    width_bad = 1'b0;
    align_bad = 1'b0;
    case (funct3_MEM)
      3'b000:  ;
      3'b001:  align_bad = lane[0];
      3'b010:  align_bad = |lane;
      3'b100:  width_bad = mem_write_MEM;
      3'b101:  begin
        width_bad = mem_write_MEM;
        align_bad = lane[0];
      end
      default: width_bad = 1'b1;
    endcase
  end

  // Only memory instructions can be bad; ALU ops reuse funct3 freely.
  assign bad    = is_mem & (width_bad | align_bad);
  assign access = is_mem & ~bad;

`ifdef DMEM_TIMEOUT_EN
  logic [7:0] wait_cnt;
  logic       buf_err;
  logic       bus_err_q;

  assign timeout    = (state == S_WAIT) && (wait_cnt == 8'(TIMEOUT_CYCLES));
  assign bus_err_WB = bus_err_q;

  // Count stalled WAIT cycles; cleared on ack, timeout, or any other state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= 8'd0;
    end else if (state == S_WAIT && !dmem_ack && !timeout) begin
      // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
      wait_cnt <= wait_cnt + 8'd1;
    end else begin
      wait_cnt <= 8'd0;
    end
  end
`else
  logic [7:0] timeout_unused;

  assign timeout_unused = 8'(TIMEOUT_CYCLES);
  assign timeout        = 1'b0;
  assign bus_err_WB     = 1'b0;
`endif

  // Request is combinational in IDLE so a zero-wait memory completes in one cycle.
  always_comb begin
    dmem_req = 1'b0;
    case (state)
      S_IDLE:  dmem_req = access;
      S_WAIT:  dmem_req = ~timeout;
      default: dmem_req = 1'b0;
    endcase
    // Reset must drop the request immediately, even mid-WAIT.
    dmem_req = dmem_req & rst_n;
  end

  assign stall_req = dmem_req & ~dmem_ack;
  assign dmem_we   = dmem_req & mem_write_MEM;
  assign dmem_addr = {alu_result_MEM[31:2], 2'b00};
  assign completes = dmem_req & dmem_ack;

  // Store byte enables and lane-replicated write data.
  always_comb begin
    strb       = 4'b1111;
    dmem_wdata = store_data_MEM;
    case (funct3_MEM[1:0])
      2'b00: begin
        strb       = 4'b0001 << lane;
        dmem_wdata = {4{store_data_MEM[7:0]}};
      end
      2'b01: begin
        strb       = 4'b0011 << lane;
        dmem_wdata = {2{store_data_MEM[15:0]}};
      end
      default: ;
    endcase
    dmem_wstrb = mem_write_MEM ? strb : 4'b0000;
  end

  // Select the addressed byte/half of the read word and extend it.
  always_comb begin
    case (lane)
      2'd0:    byte_v = dmem_rdata[7:0];
      2'd1:    byte_v = dmem_rdata[15:8];
      2'd2:    byte_v = dmem_rdata[23:16];
      default: byte_v = dmem_rdata[31:24];
    endcase
    half_v = lane[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (funct3_MEM)
      3'b000:  load_data = {{24{byte_v[7]}}, byte_v};
      3'b100:  load_data = {24'd0, byte_v};
      3'b001:  load_data = {{16{half_v[15]}}, half_v};
      3'b101:  load_data = {16'd0, half_v};
      default: load_data = dmem_rdata;
    endcase
  end

  // Data captured into WB on a normal edge; bad or abandoned loads carry 0.
  always_comb begin
    if (timeout || (mem_read_MEM && bad)) begin
      cap_data = 32'd0;
    end else if (mem_read_MEM) begin
      cap_data = load_data;
    end else begin
      cap_data = alu_result_MEM;
    end
  end

  // Access FSM; parks completed data in a buffer while WB is held by bubbleW.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      // NOTE: the one-entry result buffer is reset so a stale word can never reach WB.
      buf_data <= 32'd0;
`ifdef DMEM_TIMEOUT_EN
      buf_err  <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (access && !dmem_ack) begin
            state <= S_WAIT;
          end else if (completes && bubbleW) begin
            buf_data <= load_data;
`ifdef DMEM_TIMEOUT_EN
            buf_err  <= 1'b0;
`endif
            state    <= S_DONE;
          end
        end
        S_WAIT: begin
          if (timeout) begin
            if (bubbleW) begin
              buf_data <= 32'd0;
`ifdef DMEM_TIMEOUT_EN
              buf_err  <= 1'b1;
`endif
              state    <= S_DONE;
            end else begin
              state <= S_IDLE;
            end
          end else if (dmem_ack) begin
            if (bubbleW) begin
              buf_data <= load_data;
`ifdef DMEM_TIMEOUT_EN
              buf_err  <= 1'b0;
`endif
              state    <= S_DONE;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_DONE: begin
          if (!bubbleW) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // WB pipeline register: hold, flush, stall bubble, buffered result, or capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_dest_WB  <= 5'd0;
      wb_data_WB   <= 32'd0;
      reg_write_WB <= 1'b0;
      misalign_WB  <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
      bus_err_q    <= 1'b0;
`endif
    end else if (bubbleW) begin
      reg_dest_WB  <= reg_dest_WB;
    end else if (flushW || stall_req) begin
      reg_dest_WB  <= 5'd0;
      wb_data_WB   <= 32'd0;
      reg_write_WB <= 1'b0;
      misalign_WB  <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
      bus_err_q    <= 1'b0;
`endif
    end else if (state == S_DONE) begin
      reg_dest_WB  <= reg_dest_MEM;
      wb_data_WB   <= buf_data;
      misalign_WB  <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
      reg_write_WB <= reg_write_MEM & ~buf_err;
      bus_err_q    <= buf_err;
`else
      reg_write_WB <= reg_write_MEM;
`endif
    end else begin
      reg_dest_WB  <= reg_dest_MEM;
      wb_data_WB   <= cap_data;
      reg_write_WB <= reg_write_MEM & ~bad & ~timeout;
      misalign_WB  <= bad;
`ifdef DMEM_TIMEOUT_EN
      bus_err_q    <= timeout;
`endif
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed-vector bench for mem_wb_stage.
// Inputs change on the falling edge; combinational outputs are sampled 1 ns
// later and registered outputs 1 ns after the rising edge.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  reg_dest_MEM;
  logic [31:0] alu_result_MEM;
  logic [31:0] store_data_MEM;
  logic [2:0]  funct3_MEM;
  logic        mem_read_MEM;
  logic        mem_write_MEM;
  logic        reg_write_MEM;
  logic        bubbleW;
  logic        flushW;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        stall_req;
  logic [4:0]  reg_dest_WB;
  logic [31:0] wb_data_WB;
  logic        reg_write_WB;
  logic        misalign_WB;
  logic        bus_err_WB;

  int n_checks = 0;
  int n_fail   = 0;

  mem_wb_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .reg_dest_MEM   (reg_dest_MEM),
    .alu_result_MEM (alu_result_MEM),
    .store_data_MEM (store_data_MEM),
    .funct3_MEM     (funct3_MEM),
    .mem_read_MEM   (mem_read_MEM),
    .mem_write_MEM  (mem_write_MEM),
    .reg_write_MEM  (reg_write_MEM),
    .bubbleW        (bubbleW),
    .flushW         (flushW),
    .dmem_req       (dmem_req),
    .dmem_we        (dmem_we),
    .dmem_addr      (dmem_addr),
    .dmem_wstrb     (dmem_wstrb),
    .dmem_wdata     (dmem_wdata),
    .dmem_ack       (dmem_ack),
    .dmem_rdata     (dmem_rdata),
    .stall_req      (stall_req),
    .reg_dest_WB    (reg_dest_WB),
    .wb_data_WB     (wb_data_WB),
    .reg_write_WB   (reg_write_WB),
    .misalign_WB    (misalign_WB),
    .bus_err_WB     (bus_err_WB)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%08h expected=%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_op(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] sdata,
                        input logic [4:0] dest, input logic rw);
    mem_read_MEM   = rd;
    mem_write_MEM  = wr;
    funct3_MEM     = f3;
    alu_result_MEM = addr;
    store_data_MEM = sdata;
    reg_dest_MEM   = dest;
    reg_write_MEM  = rw;
  endtask

  task automatic set_bus(input logic ack, input logic [31:0] rdata);
    dmem_ack   = ack;
    dmem_rdata = rdata;
  endtask

  task automatic check_wb(input string tag, input logic [4:0] dest, input logic [31:0] data,
                          input logic rw, input logic mis);
    check({tag, ".dest"}, reg_dest_WB, dest);
    check({tag, ".data"}, wb_data_WB, data);
    check({tag, ".rw"}, reg_write_WB, rw);
    check({tag, ".mis"}, misalign_WB, mis);
    check({tag, ".err"}, bus_err_WB, 1'b0);
  endtask

  // Zero-wait load: one cycle, no stall, result after the next rising edge.
  task automatic quick_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] rdata, input logic [31:0] exp);
    @(negedge clk);
    set_op(1'b1, 1'b0, f3, addr, 32'd0, 5'd10, 1'b1);
    set_bus(1'b1, rdata);
    #1;
    check({tag, ".stall"}, stall_req, 1'b0);
    @(posedge clk); #1;
    check_wb(tag, 5'd10, exp, 1'b1, 1'b0);
  endtask

  // Zero-wait store: checks strobes and lane-replicated data.
  task automatic quick_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] sdata, input logic [3:0] exp_strb,
                             input logic [31:0] exp_wdata);
    @(negedge clk);
    set_op(1'b0, 1'b1, f3, addr, sdata, 5'd0, 1'b0);
    set_bus(1'b1, 32'd0);
    #1;
    check({tag, ".req"}, dmem_req, 1'b1);
    check({tag, ".we"}, dmem_we, 1'b1);
    check({tag, ".strb"}, dmem_wstrb, exp_strb);
    check({tag, ".wdata"}, dmem_wdata, exp_wdata);
    check({tag, ".addr"}, dmem_addr, {addr[31:2], 2'b00});
    check({tag, ".stall"}, stall_req, 1'b0);
    @(posedge clk); #1;
    check_wb(tag, 5'd0, addr, 1'b0, 1'b0);
  endtask

  // Bad access: no request, no stall, flagged one edge later.
  task automatic bad_access(input string tag, input logic rd, input logic [2:0] f3,
                            input logic [31:0] addr);
    @(negedge clk);
    set_op(rd, ~rd, f3, addr, 32'h1234_5678, 5'd7, 1'b1);
    set_bus(1'b0, 32'd0);
    #1;
    check({tag, ".req"}, dmem_req, 1'b0);
    check({tag, ".stall"}, stall_req, 1'b0);
    @(posedge clk); #1;
    check({tag, ".dest"}, reg_dest_WB, 5'd7);
    check({tag, ".rw"}, reg_write_WB, 1'b0);
    check({tag, ".mis"}, misalign_WB, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    bubbleW = 1'b0;
    flushW = 1'b0;
    set_op(1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 5'd0, 1'b0);
    set_bus(1'b0, 32'd0);
    #1;
    check("reset.req", dmem_req, 1'b0);
    check("reset.stall", stall_req, 1'b0);
    check_wb("reset", 5'd0, 32'd0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // LB sign extension, zero-wait, lane 3.
    @(negedge clk);
    set_op(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'd0, 5'd5, 1'b1);
    set_bus(1'b1, 32'h80FF_FF7F);
    #1;
    check("lb.req", dmem_req, 1'b1);
    check("lb.we", dmem_we, 1'b0);
    check("lb.addr", dmem_addr, 32'h0000_1000);
    check("lb.stall", stall_req, 1'b0);
    @(posedge clk); #1;
    check_wb("lb", 5'd5, 32'hFFFF_FF80, 1'b1, 1'b0);

    // Other load widths and lanes.
    quick_load("lbu", 3'b100, 32'h0000_1003, 32'h80FF_FF7F, 32'h0000_0080);
    quick_load("lb0", 3'b000, 32'h0000_1000, 32'h80FF_FF7F, 32'h0000_007F);
    quick_load("lh_hi", 3'b001, 32'h0000_0012, 32'h8001_0000, 32'hFFFF_8001);
    quick_load("lhu_lo", 3'b101, 32'h0000_0014, 32'h1234_F00D, 32'h0000_F00D);
    quick_load("lw", 3'b010, 32'h0000_0020, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

    // Stores.
    quick_store("sh", 3'b001, 32'h0000_2002, 32'h0000_ABCD, 4'b1100, 32'hABCD_ABCD);
    quick_store("sb", 3'b000, 32'h0000_3001, 32'h1234_5678, 4'b0010, 32'h7878_7878);
    quick_store("sw", 3'b010, 32'h0000_3004, 32'h1234_5678, 4'b1111, 32'h1234_5678);

    // Misaligned and illegal-width accesses.
    bad_access("lw_mis", 1'b1, 3'b010, 32'h0000_0001);
    bad_access("lh_mis", 1'b1, 3'b001, 32'h0000_0003);
    bad_access("sw_mis", 1'b0, 3'b010, 32'h0000_0002);
    bad_access("ld_f3", 1'b1, 3'b011, 32'h0000_0000);
    bad_access("st_f3", 1'b0, 3'b100, 32'h0000_0000);

    // Non-memory pass-through, including a funct3 that is illegal for memory ops.
    @(negedge clk);
    set_op(1'b0, 1'b0, 3'b011, 32'h0000_0055, 32'd0, 5'd4, 1'b1);
    set_bus(1'b0, 32'd0);
    #1;
    check("alu.req", dmem_req, 1'b0);
    @(posedge clk); #1;
    check_wb("alu", 5'd4, 32'h0000_0055, 1'b1, 1'b0);

    // bubbleW holds the WB register.
    @(negedge clk);
    bubbleW = 1'b1;
    set_op(1'b0, 1'b0, 3'b000, 32'h0000_0077, 32'd0, 5'd6, 1'b1);
    @(posedge clk); #1;
    check_wb("hold", 5'd4, 32'h0000_0055, 1'b1, 1'b0);

    // flushW zeroes it.
    @(negedge clk);
    bubbleW = 1'b0;
    flushW = 1'b1;
    @(posedge clk); #1;
    check_wb("flush", 5'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    flushW = 1'b0;

    // LHU with ack three cycles after request start.
    set_op(1'b1, 1'b0, 3'b101, 32'h0000_0010, 32'd0, 5'd9, 1'b1);
    set_bus(1'b0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("lhu_wait%0d.stall", i), stall_req, 1'b1);
      check($sformatf("lhu_wait%0d.addr", i), dmem_addr, 32'h0000_0010);
      @(posedge clk); #1;
      check($sformatf("lhu_wait%0d.dest", i), reg_dest_WB, 5'd0);
      check($sformatf("lhu_wait%0d.rw", i), reg_write_WB, 1'b0);
      @(negedge clk);
    end
    set_bus(1'b1, 32'h8001_0000);
    #1;
    check("lhu_ack.stall", stall_req, 1'b0);
    check("lhu_ack.req", dmem_req, 1'b1);
    @(posedge clk); #1;
    check_wb("lhu", 5'd9, 32'h0000_0000, 1'b1, 1'b0);
    quick_load("lhu_hi", 3'b101, 32'h0000_0012, 32'h8001_0000, 32'h0000_8001);

    // Ack arrives while bubbleW holds WB: result parked, delivered once.
    @(negedge clk);
    set_op(1'b1, 1'b0, 3'b010, 32'h0000_0020, 32'd0, 5'd3, 1'b1);
    set_bus(1'b0, 32'd0);
    #1;
    check("buf_start.stall", stall_req, 1'b1);
    @(posedge clk);
    @(negedge clk);
    bubbleW = 1'b1;
    set_bus(1'b1, 32'hCAFE_F00D);
    #1;
    check("buf_ack.stall", stall_req, 1'b0);
    @(posedge clk); #1;
    check_wb("buf_held", 5'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    set_bus(1'b0, 32'h1111_1111);
    #1;
    check("buf_done.req", dmem_req, 1'b0);
    check("buf_done.stall", stall_req, 1'b0);
    @(posedge clk); #1;
    check_wb("buf_still", 5'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    bubbleW = 1'b0;
    #1;
    check("buf_release.req", dmem_req, 1'b0);
    @(posedge clk); #1;
    check_wb("buf_out", 5'd3, 32'hCAFE_F00D, 1'b1, 1'b0);
    @(negedge clk);
    set_op(1'b0, 1'b0, 3'b000, 32'h0000_0099, 32'd0, 5'd8, 1'b1);
    @(posedge clk); #1;
    check_wb("buf_after", 5'd8, 32'h0000_0099, 1'b1, 1'b0);

`ifdef DMEM_TIMEOUT_EN
    // No ack: one IDLE and four WAIT stall cycles, then abandonment.
    @(negedge clk);
    set_op(1'b1, 1'b0, 3'b010, 32'h0000_0050, 32'd0, 5'd2, 1'b1);
    set_bus(1'b0, 32'd0);
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("to_wait%0d.stall", i), stall_req, 1'b1);
      @(negedge clk);
    end
    #1;
    check("to.req", dmem_req, 1'b0);
    check("to.stall", stall_req, 1'b0);
    @(posedge clk); #1;
    check("to.err", bus_err_WB, 1'b1);
    check("to.rw", reg_write_WB, 1'b0);
    check("to.data", wb_data_WB, 32'd0);
    @(negedge clk);
    set_op(1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 5'd0, 1'b0);
`endif

    // Reset in the middle of a WAIT drops the request at once.
    @(negedge clk);
    set_op(1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'd0, 5'd12, 1'b1);
    set_bus(1'b0, 32'd0);
    @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_wait.req_before", dmem_req, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_wait.req", dmem_req, 1'b0);
    check("rst_wait.stall", stall_req, 1'b0);
    check_wb("rst_wait", 5'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    set_op(1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 5'd0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("post_rst.req", dmem_req, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
